sample_pwm_out: RTL and testbench
=================================

// Module: sample_pwm_out
// PURPOSE
//  Output stage downstream of the sequential divider. Paces the sample rate by issuing sample_now to
//  the divider, captures each 8-bit shaped sample on done, double-buffers it and drives a PWM audio
//  pin. Flags underrun when the divider misses a sample window.
// PARAMETERS
//  PWM_W               8   PWM resolution; sample width; PWM period = 2**PWM_W clk cycles
//  PERIODS_PER_SAMPLE  4   PWM periods per sample interval (>=1); default = 1024 clk per sample
// PORTS
//  clk         in   1      system clock
//  nrst        in   1      asynchronous, active-low reset
//  en          in   1      output enable; 0 = muted, counters held at 0
//  q_in        in   PWM_W  shaped sample from divider (q_out)
//  done        in   1      one-cycle pulse: q_in valid this cycle
//  clr_underrun in  1      synchronous clear of underrun flag
//  sample_now  out  1      one-cycle pulse: divider loads operands and starts
//  pwm_out     out  1      PWM audio output
//  underrun    out  1      sticky: a sample_now was issued with no done since the previous one
// BEHAVIOUR
//  Reset: all registers 0; sample_now=0, pwm_out=0, underrun=0, duty=0, pending empty, FSM=IDLE.
//  Counters: pwm_cnt (PWM_W bits) increments every clk while en, wraps 2**PWM_W-1 -> 0;
//   per_cnt increments at each pwm_cnt wrap, wraps PERIODS_PER_SAMPLE-1 -> 0.
//  sample_now: registered; high for exactly 1 cycle after the cycle where pwm_cnt==max and
//   per_cnt==PERIODS_PER_SAMPLE-1 (and en). First pulse 2**PWM_W*PERIODS_PER_SAMPLE cycles after en rises.
//  FSM (enum): IDLE -> WAIT_DONE on en rise; WAIT_DONE -> HAVE_SAMPLE on done;
//   HAVE_SAMPLE -> WAIT_DONE on sample_now; WAIT_DONE + sample_now -> stays WAIT_DONE, underrun<=1;
//   any state -> IDLE when en=0. First sample_now after en rise does not raise underrun.
//  Capture: done pulse loads pending<=q_in, pending_vld<=1 (any state except IDLE). done with
//   pending_vld already 1 overwrites (newest wins); no flag. Done in IDLE is ignored.
//  Apply: at pwm_cnt wrap (cycle where pwm_cnt becomes 0), if pending_vld: duty<=pending,
//   pending_vld<=0. Otherwise duty holds previous value (underrun => sample repeated, not zeroed).
//   Capture-to-audible latency: <= 2**PWM_W cycles after done.
//  pwm_out: registered; = en & (pwm_cnt < duty). duty=0 -> constant 0; duty=max -> high max/2**PWM_W.
//   Duty changes only at period boundary: no glitch/truncated pulse within a period.
//  Simultaneous: done and sample_now same cycle -> done counts for the closing interval (no
//   underrun), FSM ends in WAIT_DONE. done and apply same cycle -> new q_in goes to pending, the old
//   pending is applied. clr_underrun with a new underrun same cycle -> set wins.
//  en falling: next cycle pwm_out=0, pwm_cnt=per_cnt=0, pending_vld=0; duty and underrun retained.
//  Reset mid-operation: immediate return to reset values; no sample_now pulse emitted on release.
//  Widths: counters unsigned, no arithmetic beyond increment/compare; per_cnt width $clog2(PPS)
//   (min 1 bit).
// STRUCTURE
//  synth_pkg: PWM_W default constant, out_state_t enum {IDLE, WAIT_DONE, HAVE_SAMPLE}.
//  One sub-module natural: pwm_gen (pwm_cnt + compare, exposes wrap strobe); FSM, sample pacing
//  and double buffer stay in this module. Single clock domain; no CDC.
// TESTING
//  1 Reset, en=1, PPS=4: sample_now pulses at cycle 1024, 2048, ... exactly 1 cycle wide; none before.
//  2 done with q_in=8'd64 40 cycles after sample_now -> duty=64 from next wrap; pwm_out high 64/256
//    cycles each period; underrun stays 0.
//  3 No done between two sample_nows (after the first) -> underrun=1, duty holds 64; clr_underrun ->0.
//  4 q_in=0 -> pwm_out never high; q_in=255 -> low exactly 1 cycle per 256.
//  5 done and sample_now same cycle -> underrun stays 0; sample applied at next wrap.
//  6 en=0 mid-period -> pwm_out 0 next cycle, no sample_now; nrst pulse mid-period -> all outputs 0.

Source files
------------

// File: rtl/sample_pwm_out_pkg.sv
// Shared types and defaults for the sample-paced PWM audio output stage.
package sample_pwm_out_pkg;

  localparam int PWM_W_DEF = 8;
  localparam int PPS_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_DONE   = 2'd1,
    HAVE_SAMPLE = 2'd2
  } out_state_t;

  // per_cnt needs at least one bit even when a sample lasts a single PWM period.
  function automatic int per_cnt_width(input int pps);
    per_cnt_width = (pps > 1) ? $clog2(pps) : 1;
  endfunction

endpackage

// File: rtl/sample_pwm_out_pwm_gen.sv
// Free-running PWM counter and comparator; the wrap strobe marks the last cycle of each period.
module sample_pwm_out_pwm_gen
  import sample_pwm_out_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [PWM_W-1:0] duty,
  output logic             wrap,
  output logic             pwm_out
);

  localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};

  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] pwm_cnt_d;
  logic             pwm_out_q;
  logic             pwm_out_d;

  assign wrap    = en & (pwm_cnt_q == CNT_MAX);
  assign pwm_out = pwm_out_q;

  // Counter advance and output compare; muting holds the counter at zero.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    pwm_out_d = 1'b0;
    if (en) begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      pwm_out_d = (pwm_cnt_q < duty);
    end else begin
      pwm_cnt_d = {PWM_W{1'b0}};
      pwm_out_d = 1'b0;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_cnt_q <= {PWM_W{1'b0}};
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

endmodule

// File: rtl/sample_pwm_out.sv
// Sample-rate pacing, divider handshake FSM, double-buffered duty and underrun tracking
// in front of the PWM generator.
module sample_pwm_out
  import sample_pwm_out_pkg::*;
#(
  parameter int PWM_W              = PWM_W_DEF,
  parameter int PERIODS_PER_SAMPLE = PPS_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [PWM_W-1:0] q_in,
  input  logic             done,
  input  logic             clr_underrun,
  output logic             sample_now,
  output logic             pwm_out,
  output logic             underrun
);

  localparam int               PER_W    = per_cnt_width(PERIODS_PER_SAMPLE);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_SAMPLE - 1);

  out_state_t       state_q;
  out_state_t       state_d;
  logic             first_q;
  logic             first_d;
  logic [PER_W-1:0] per_cnt_q;
  logic [PER_W-1:0] per_cnt_d;
  logic             sample_now_q;
  logic             sample_now_d;
  logic             underrun_q;
  logic             underrun_d;
  logic             underrun_set;
  logic [PWM_W-1:0] pending_q;
  logic [PWM_W-1:0] pending_d;
  logic             pending_vld_q;
  logic             pending_vld_d;
  logic [PWM_W-1:0] duty_q;
  logic [PWM_W-1:0] duty_d;
  logic             wrap;

  assign sample_now = sample_now_q;
  assign underrun   = underrun_q;

  sample_pwm_out_pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm_gen (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .duty    (duty_q),
    .wrap    (wrap),
    .pwm_out (pwm_out)
  );

  // Sample pacing: count PWM periods and request a sample on the last wrap of the interval.
  always_comb begin
    per_cnt_d    = per_cnt_q;
    sample_now_d = 1'b0;
    if (!en) begin
      per_cnt_d    = {PER_W{1'b0}};
      sample_now_d = 1'b0;
    end else if (wrap) begin
      sample_now_d = (per_cnt_q == PER_LAST);
      per_cnt_d    = (per_cnt_q == PER_LAST) ? {PER_W{1'b0}} : per_cnt_q + PER_W'(1);
    end else begin
      per_cnt_d    = per_cnt_q;
      sample_now_d = 1'b0;
    end
  end

  // Handshake FSM; first_q exempts the opening sample_now, which has no earlier window to miss.
  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    underrun_set = 1'b0;
    if (!en) begin
      state_d = IDLE;
      first_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_DONE;
          first_d = 1'b1;
        end
        WAIT_DONE: begin
          if (sample_now_q) begin
            state_d      = WAIT_DONE;
            first_d      = 1'b0;
            underrun_set = ~done & ~first_q;
          end else if (done) begin
            state_d = HAVE_SAMPLE;
          end else begin
            state_d = WAIT_DONE;
          end
        end
        HAVE_SAMPLE: begin
          if (sample_now_q) begin
            state_d = WAIT_DONE;
            first_d = 1'b0;
          end else begin
            state_d = HAVE_SAMPLE;
          end
        end
        default: begin
          state_d = IDLE;
          first_d = 1'b0;
        end
      endcase
    end
  end

  // Sticky underrun; a new miss beats a simultaneous clear.
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Double buffer: apply the old pending value at the wrap before a same-cycle capture replaces it.
  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    duty_d        = duty_q;
    if (!en) begin
      pending_vld_d = 1'b0;
    end else begin
      if (wrap && pending_vld_q) begin
        duty_d        = pending_q;
        pending_vld_d = 1'b0;
      end else begin
        duty_d = duty_q;
      end
      if (done && (state_q != IDLE)) begin
        pending_d     = q_in;
        pending_vld_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      per_cnt_q     <= {PER_W{1'b0}};
      sample_now_q  <= 1'b0;
      underrun_q    <= 1'b0;
      pending_q     <= {PWM_W{1'b0}};
      pending_vld_q <= 1'b0;
      duty_q        <= {PWM_W{1'b0}};
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      per_cnt_q     <= per_cnt_d;
      sample_now_q  <= sample_now_d;
      underrun_q    <= underrun_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      duty_q        <= duty_d;
    end
  end

endmodule

// File: tb/tb_sample_pwm_out.sv
// Self-checking bench for sample_pwm_out: directed per-interval table, hand sequences for
// mute/reset, and randomized traffic against a cycle-count based reference model.
module tb_sample_pwm_out;

  localparam int PERIOD   = 256;
  localparam int PPS      = 4;
  localparam int INTERVAL = PERIOD * PPS;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic [7:0] q_in;
  logic       done;
  logic       clr_underrun;
  logic       sample_now;
  logic       pwm_out;
  logic       underrun;

  always #5 clk = ~clk;

  sample_pwm_out #(
    .PWM_W              (8),
    .PERIODS_PER_SAMPLE (PPS)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .q_in         (q_in),
    .done         (done),
    .clr_underrun (clr_underrun),
    .sample_now   (sample_now),
    .pwm_out      (pwm_out),
    .underrun     (underrun)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: m_n counts enabled cycles since enable; phase comes from m_n arithmetic.
  int m_n;
  bit m_active;
  bit m_got;
  bit m_first;
  bit m_vld;
  bit m_sn;
  bit m_pwm;
  bit m_ur;
  int m_duty;
  int m_pend;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_active = 0; m_got = 0; m_first = 0; m_vld = 0;
    m_sn = 0; m_pwm = 0; m_ur = 0; m_duty = 0; m_pend = 0;
  endtask

  task automatic model_edge(input bit e, input bit d, input int q, input bit c);
    int cnt;
    bit wrap;
    bit set_ur;
    bit new_sn;
    bit new_pwm;
    if (!e) begin
      m_n = 0; m_active = 0; m_got = 0; m_first = 0; m_vld = 0; m_sn = 0; m_pwm = 0;
      if (c) m_ur = 0;
    end else begin
      cnt     = m_n % PERIOD;
      wrap    = (cnt == PERIOD - 1);
      new_sn  = wrap && (((m_n / PERIOD) % PPS) == PPS - 1);
      new_pwm = (cnt < m_duty);
      set_ur  = m_active && m_sn && !m_first && !m_got && !d;
      if (!m_active) begin
        m_got = 0; m_first = 1;
      end else if (m_sn) begin
        m_got = 0; m_first = 0;
      end else if (d) begin
        m_got = 1;
      end
      if (wrap && m_vld) begin
        m_duty = m_pend; m_vld = 0;
      end
      if (m_active && d) begin
        m_pend = q; m_vld = 1;
      end
      if (set_ur) m_ur = 1;
      else if (c) m_ur = 0;
      m_active = 1;
      m_pwm    = new_pwm;
      m_sn     = new_sn;
      m_n++;
    end
  endtask

  task automatic step(input bit e, input bit d, input int q, input bit c);
    en           = e;
    done         = d;
    q_in         = 8'(q);
    clr_underrun = c;
    @(posedge clk);
    model_edge(e, d, q, c);
    #1;
    check("sample_now", int'(sample_now), int'(m_sn));
    check("pwm_out", int'(pwm_out), int'(m_pwm));
    check("underrun", int'(underrun), int'(m_ur));
  endtask

  typedef struct {
    bit give_done;
    int done_ofs;
    int q;
    bit clr;
    bit exp_ur_mid;
    bit exp_ur_end;
    int exp_high;
  } vec_t;

  vec_t vt[8];

  initial begin
    int cnt_a;
    int cnt_b;
    int high;
    bit e_r;

    vt[0] = '{1'b1, 40, 64,  1'b0, 1'b0, 1'b0, 64};
    vt[1] = '{1'b0, 0,  0,   1'b0, 1'b0, 1'b0, 64};
    vt[2] = '{1'b1, 40, 0,   1'b1, 1'b1, 1'b0, 0};
    vt[3] = '{1'b1, 40, 255, 1'b0, 1'b0, 1'b0, 255};
    vt[4] = '{1'b0, 0,  0,   1'b0, 1'b0, 1'b0, 255};
    vt[5] = '{1'b1, 0,  128, 1'b0, 1'b0, 1'b0, 128};
    vt[6] = '{1'b0, 0,  0,   1'b0, 1'b1, 1'b1, 128};
    vt[7] = '{1'b1, 40, 200, 1'b1, 1'b1, 1'b0, 200};

    nrst = 1'b0; en = 1'b0; done = 1'b0; clr_underrun = 1'b0; q_in = 8'd0;
    model_reset();
    #12;
    check("rst_sample_now", int'(sample_now), 0);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_underrun", int'(underrun), 0);
    nrst = 1'b1;

    // First sample_now lands exactly INTERVAL enabled cycles after enable.
    cnt_a = 0;
    for (int k = 1; k < INTERVAL; k++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      cnt_a += int'(sample_now);
    end
    check("sn_early", cnt_a, 0);
    step(1'b1, 1'b0, 0, 1'b0);
    check("sn_first", int'(sample_now), 1);

    // One table row per sample interval, starting on its sample_now cycle.
    for (int i = 0; i < 8; i++) begin
      high = 0;
      for (int ofs = 0; ofs < INTERVAL; ofs++) begin
        if (ofs == 50) check("ur_mid", int'(underrun), int'(vt[i].exp_ur_mid));
        if (ofs >= 512 && ofs < 768) high += int'(pwm_out);
        step(1'b1, vt[i].give_done && (ofs == vt[i].done_ofs), vt[i].q,
             vt[i].clr && (ofs == 100));
      end
      check("ur_end", int'(underrun), int'(vt[i].exp_ur_end));
      check("high_cycles", high, vt[i].exp_high);
      check("sn_interval", int'(sample_now), 1);
    end

    // Mute mid-period while the output is high.
    for (int k = 0; k < 100; k++) step(1'b1, 1'b0, 0, 1'b0);
    check("pwm_before_mute", int'(pwm_out), 1);
    step(1'b0, 1'b0, 0, 1'b0);
    check("pwm_mute", int'(pwm_out), 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 1500; k++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      cnt_a += int'(sample_now);
      cnt_b += int'(pwm_out);
    end
    check("mute_sn_count", cnt_a, 0);
    check("mute_pwm_count", cnt_b, 0);

    // Re-enable, then pulse reset mid-period: outputs drop at once, pacing restarts.
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 0, 1'b0);
    check("pwm_before_rst", int'(pwm_out), 1);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_mid_sample_now", int'(sample_now), 0);
    check("rst_mid_pwm_out", int'(pwm_out), 0);
    check("rst_mid_underrun", int'(underrun), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_pwm_out", int'(pwm_out), 0);
    nrst = 1'b1;
    cnt_a = 0;
    for (int k = 1; k < INTERVAL; k++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      cnt_a += int'(sample_now);
    end
    check("sn_after_rst_early", cnt_a, 0);
    step(1'b1, 1'b0, 0, 1'b0);
    check("sn_after_rst", int'(sample_now), 1);

    // Randomized traffic against the model.
    e_r = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 1999) == 0) e_r = ~e_r;
      step(e_r, $urandom_range(0, 199) == 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
